// File: rtl/hpi_target.sv
// hpi_target: CY7C67200 HPI responder with internal word memory and mailboxes (define HPI_TARGET_AUTOINC_EN for DATA post-increment)
module hpi_target #(
  parameter int MEM_WORDS  = 1024,
  parameter int MIN_RD_CYC = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  output logic        OTG_INT,
  output logic [15:0] dev_mbx_rdata,
  output logic        dev_mbx_valid,
  input  logic        dev_mbx_ack,
  input  logic [15:0] dev_mbx_wdata,
  input  logic        dev_mbx_wr,
  output logic        dev_mbx_busy
);
  // MIN_RD_CYC is documentary only (the read window is not enforced); folding it in keeps it referenced
  localparam int AW = $clog2(MEM_WORDS) + 0 * MIN_RD_CYC;
`ifdef HPI_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_RD_LATCH, S_RD_DRIVE, S_WR_HOLD, S_COMMIT} state_t;
  state_t r_st, w_nxt;
  logic r_cs1, r_rd1, r_wr1, r_rstn1, r_rd2, r_wr2;
  logic [1:0] r_a1, r_sel;
  logic [15:0] r_d1, r_addr, r_rdq, r_wrq, r_hdat, r_ddat;
  logic r_hval, r_busy, r_ovr, r_blk;
  logic [15:0] r_mem [MEM_WORDS];
  logic w_srst, w_rd_go, w_wr_go, w_rd_done, w_commit, w_inc, w_mclr, w_mcommit;
  logic [AW-1:0] w_idx;
  logic [15:0] w_rsel;
  assign w_srst    = Reset | ~r_rstn1;
  assign w_rd_go   = ~r_cs1 & ~r_rd1 & r_rd2;
  assign w_wr_go   = ~r_cs1 & ~r_wr1 & ~r_blk;
  assign w_rd_done = (r_st == S_RD_DRIVE) & r_rd1;
  assign w_commit  = (r_st == S_COMMIT);
  assign w_inc     = AUTOINC & (r_sel == 2'd0) & (w_rd_done | w_commit);
  assign w_mclr    = w_rd_done & (r_sel == 2'd1);
  assign w_mcommit = w_commit & (r_sel == 2'd1);
  assign w_idx     = r_addr[AW:1];
  assign w_rsel    = (r_sel == 2'd0) ? r_mem[w_idx] :
                     (r_sel == 2'd1) ? r_ddat :
                     (r_sel == 2'd2) ? r_addr : {13'b0, r_ovr, r_hval, r_busy};
  assign OTG_DATA      = (r_st == S_RD_DRIVE && !OTG_CS_N && !OTG_RD_N) ? r_rdq : 16'bz;
  assign OTG_INT       = r_busy;
  assign dev_mbx_busy  = r_busy;
  assign dev_mbx_valid = r_hval;
  assign dev_mbx_rdata = r_hdat;
  // register the pins once (s1) and keep the previous strobe levels (s2) for edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {r_cs1, r_rd1, r_wr1, r_rstn1, r_rd2, r_wr2} <= '1;
      r_a1 <= '0;
      r_d1 <= '0;
    end else begin
      {r_cs1, r_rd1, r_wr1, r_rstn1} <= {OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N};
      r_a1 <= OTG_ADDR;
      r_d1 <= OTG_DATA;
      r_rd2 <= r_rd1;
      r_wr2 <= r_wr1;
    end
  end
  // access state register; a soft reset aborts whatever access is in flight
  always_ff @(posedge Clk) begin
    if (w_srst) r_st <= S_IDLE;
    else r_st <= w_nxt;
  end
  // next access phase: a read needs an RD_N falling edge, a write holds until WR_N rises
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      S_IDLE:     w_nxt = w_rd_go ? S_RD_LATCH : w_wr_go ? S_WR_HOLD : S_IDLE;
      S_RD_LATCH: w_nxt = S_RD_DRIVE;
      S_RD_DRIVE: w_nxt = r_rd1 ? S_IDLE : S_RD_DRIVE;
      S_WR_HOLD:  w_nxt = (r_wr1 & ~r_wr2) ? S_COMMIT : S_WR_HOLD;
      default:    w_nxt = S_IDLE;
    endcase
  end
  // register file, mailboxes and write-suppression after a read/write strobe conflict
  always_ff @(posedge Clk) begin
    if (w_srst) begin
      {r_sel, r_addr, r_rdq, r_wrq, r_hdat, r_ddat} <= '0;
      {r_hval, r_busy, r_ovr, r_blk} <= '0;
    end else begin
      if (r_st == S_IDLE || (r_st == S_WR_HOLD && !r_wr1)) r_sel <= r_a1;
      if (r_st == S_RD_LATCH) r_rdq <= w_rsel;
      if (r_st == S_WR_HOLD && !r_wr1) r_wrq <= r_d1;
      r_blk <= (r_st == S_IDLE && w_rd_go && !r_wr1) || (r_blk && !(r_rd1 && r_wr1));
      if (w_commit && r_sel == 2'd2) r_addr <= r_wrq;
      else if (w_inc) r_addr <= r_addr + 16'd2;
      if (w_commit && r_sel == 2'd3) r_ovr <= 1'b0;
      else if (w_mcommit && r_hval && !dev_mbx_ack) r_ovr <= 1'b1;
      if (w_mcommit) begin
        r_hdat <= r_wrq;
        r_hval <= 1'b1;
      end else if (dev_mbx_ack) r_hval <= 1'b0;
      if (dev_mbx_wr && (!r_busy || w_mclr)) begin
        r_ddat <= dev_mbx_wdata;
        r_busy <= 1'b1;
      end else if (w_mclr) r_busy <= 1'b0;
    end
  end
  // word memory keeps its contents across resets
  always_ff @(posedge Clk) begin
    if (!w_srst && w_commit && r_sel == 2'd0) r_mem[w_idx] <= r_wrq;
  end
endmodule

// File: tb/tb_hpi_target.sv
// tb_hpi_target: randomized and directed host/device traffic against a register-level model
module tb_hpi_target;
  localparam int MW = 1024;
`ifdef HPI_TARGET_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, cs_n, rd_n, wr_n, rst_n, ack, dwr, tb_oe, irq, valid, busy;
  logic [1:0] a;
  logic [15:0] tb_d, dwd, rdata;
  wire [15:0] bus;
  int checks = 0, failures = 0;
  assign bus = tb_oe ? tb_d : 16'bz;
  pullup (bus);
  hpi_target #(.MEM_WORDS(MW), .MIN_RD_CYC(3)) dut (
    .Clk(clk), .Reset(rst), .OTG_DATA(bus), .OTG_ADDR(a), .OTG_CS_N(cs_n), .OTG_RD_N(rd_n),
    .OTG_WR_N(wr_n), .OTG_RST_N(rst_n), .OTG_INT(irq), .dev_mbx_rdata(rdata), .dev_mbx_valid(valid),
    .dev_mbx_ack(ack), .dev_mbx_wdata(dwd), .dev_mbx_wr(dwr), .dev_mbx_busy(busy)
  );
  always #5 clk = ~clk;
  logic [15:0] m_mem [MW];
  bit m_val [MW];
  logic [15:0] m_addr, m_hdat, m_ddat;
  bit m_hval, m_busy, m_ovr;
  function automatic int m_idx(input logic [15:0] ad);
    return (int'(ad) / 2) % MW;
  endfunction
  function automatic void m_reset();
    m_addr = 0; m_hdat = 0; m_ddat = 0; m_hval = 0; m_busy = 0; m_ovr = 0;
  endfunction
  function automatic void m_write(input logic [1:0] r, input logic [15:0] d, input bit ak);
    case (r)
      2'd0: begin
        m_mem[m_idx(m_addr)] = d;
        m_val[m_idx(m_addr)] = 1;
        if (AI) m_addr = m_addr + 16'd2;
      end
      2'd1: begin
        if (m_hval && !ak) m_ovr = 1;
        m_hval = 1;
        m_hdat = d;
      end
      2'd2: m_addr = d;
      default: m_ovr = 0;
    endcase
    if (ak && r != 2'd1) m_hval = 0;
  endfunction
  function automatic logic [15:0] m_read(input logic [1:0] r);
    logic [15:0] v;
    case (r)
      2'd0: begin
        v = m_mem[m_idx(m_addr)];
        if (AI) m_addr = m_addr + 16'd2;
      end
      2'd1: begin
        v = m_ddat;
        m_busy = 0;
      end
      2'd2: v = m_addr;
      default: v = {13'b0, m_ovr, m_hval, m_busy};
    endcase
    return v;
  endfunction
  function automatic void m_post(input logic [15:0] d);
    if (!m_busy) begin
      m_ddat = d;
      m_busy = 1;
    end
  endfunction
  task automatic hw(input logic [1:0] r, input logic [15:0] d, input bit ak);
    a = r; tb_d = d; tb_oe = 1; cs_n = 0; wr_n = 0;
    repeat (2) @(negedge clk);
    wr_n = 1; cs_n = 1; tb_oe = 0;
    repeat (2) @(negedge clk);
    if (ak) begin
      ack = 1;
      @(negedge clk);
      ack = 0;
    end
    m_write(r, d, ak);
  endtask
  task automatic hr(input logic [1:0] r, input bit pst, input logic [15:0] pd,
                    output logic [15:0] v, output logic [15:0] e, output bit known);
    known = (r != 2'd0) || m_val[m_idx(m_addr)];
    e = m_read(r);
    a = r; cs_n = 0; rd_n = 0;
    repeat (4) @(negedge clk);
    v = bus;
    rd_n = 1; cs_n = 1;
    @(negedge clk);
    if (pst) begin
      dwr = 1;
      dwd = pd;
    end
    @(negedge clk);
    dwr = 0;
    if (pst) m_post(pd);
  endtask
  task automatic post(input logic [15:0] d);
    dwr = 1; dwd = d;
    @(negedge clk);
    dwr = 0;
    m_post(d);
  endtask
  task automatic pulse_ack();
    ack = 1;
    @(negedge clk);
    ack = 0;
    m_hval = 0;
  endtask
  task automatic test_reset();
    logic [15:0] v, e;
    bit k;
    rst = 1;
    repeat (4) @(negedge clk);
    rst = 0;
    @(negedge clk);
    m_reset();
    if ({irq, valid, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {irq, valid, busy}); end
    checks++;
    if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    checks++;
    if (bus !== 16'hFFFF) begin failures++; $display("FAIL reset_bus_released got=%h exp=FFFF", bus); end
    checks++;
    hr(2'd3, 0, 16'h0, v, e, k);
    if (v !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=0000", v); end
    checks++;
    if (bus !== 16'hFFFF) begin failures++; $display("FAIL bus_after_read got=%h exp=FFFF", bus); end
    checks++;
  endtask
  task automatic test_autoinc();
    logic [15:0] v, e, x [3];
    bit k;
    x[0] = AI ? 16'h00A1 : 16'h00C3;
    x[1] = AI ? 16'h00B2 : 16'h00C3;
    x[2] = 16'h00C3;
    hw(2'd2, 16'h1000, 0);
    hw(2'd0, 16'h00A1, 0);
    hw(2'd0, 16'h00B2, 0);
    hw(2'd0, 16'h00C3, 0);
    hw(2'd2, 16'h1000, 0);
    for (int i = 0; i < 3; i++) begin
      hr(2'd0, 0, 16'h0, v, e, k);
      if (v !== x[i]) begin failures++; $display("FAIL data_seq[%0d] got=%h exp=%h", i, v, x[i]); end
      checks++;
    end
  endtask
  task automatic test_wrap();
    logic [15:0] v, e, xa;
    bit k;
    xa = AI ? 16'h0000 : 16'hFFFE;
    hw(2'd2, 16'hFFFE, 0);
    hw(2'd0, 16'h5555, 0);
    hr(2'd2, 0, 16'h0, v, e, k);
    if (v !== xa) begin failures++; $display("FAIL addr_wrap_wr got=%h exp=%h", v, xa); end
    checks++;
    hw(2'd2, 16'hFFFE, 0);
    hr(2'd0, 0, 16'h0, v, e, k);
    if (v !== 16'h5555) begin failures++; $display("FAIL top_word got=%h exp=5555", v); end
    checks++;
    hr(2'd2, 0, 16'h0, v, e, k);
    if (v !== xa) begin failures++; $display("FAIL addr_wrap_rd got=%h exp=%h", v, xa); end
    checks++;
    hw(2'd2, 16'h0002, 0);
    hw(2'd0, 16'h6A6A, 0);
    hw(2'd2, 16'h0802, 0);
    hr(2'd0, 0, 16'h0, v, e, k);
    if (v !== 16'h6A6A) begin failures++; $display("FAIL mem_alias got=%h exp=6A6A", v); end
    checks++;
  endtask
  task automatic test_dev_mbx();
    logic [15:0] v, e;
    bit k;
    post(16'h1234);
    if ({irq, busy} !== 2'b11) begin failures++; $display("FAIL dev_post_int got=%b exp=11", {irq, busy}); end
    checks++;
    hr(2'd3, 0, 16'h0, v, e, k);
    if (v !== 16'h0001) begin failures++; $display("FAIL dev_status got=%h exp=0001", v); end
    checks++;
    post(16'h9999);
    hr(2'd1, 0, 16'h0, v, e, k);
    if (v !== 16'h1234) begin failures++; $display("FAIL dev_mbx_word got=%h exp=1234", v); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL int_cleared got=%b exp=0", irq); end
    checks++;
    if (bus !== 16'hFFFF) begin failures++; $display("FAIL bus_after_mbx got=%h exp=FFFF", bus); end
    checks++;
    post(16'hAAAA);
    hr(2'd1, 1, 16'hBEEF, v, e, k);
    if (v !== 16'hAAAA) begin failures++; $display("FAIL race_first got=%h exp=AAAA", v); end
    checks++;
    if ({irq, busy} !== 2'b11) begin failures++; $display("FAIL race_busy got=%b exp=11", {irq, busy}); end
    checks++;
    hr(2'd1, 0, 16'h0, v, e, k);
    if (v !== 16'hBEEF) begin failures++; $display("FAIL race_second got=%h exp=BEEF", v); end
    checks++;
  endtask
  task automatic test_host_mbx();
    logic [15:0] v, e;
    bit k;
    hw(2'd1, 16'h0001, 0);
    hw(2'd1, 16'h0002, 0);
    @(negedge clk);
    if (rdata !== 16'h0002 || valid !== 1'b1) begin failures++; $display("FAIL host_mbx got=%h/%b exp=0002/1", rdata, valid); end
    checks++;
    hr(2'd3, 0, 16'h0, v, e, k);
    if (v !== 16'h0006) begin failures++; $display("FAIL ovr_status got=%h exp=0006", v); end
    checks++;
    hw(2'd3, 16'hFFFF, 0);
    hr(2'd3, 0, 16'h0, v, e, k);
    if (v !== 16'h0002) begin failures++; $display("FAIL ovr_clear got=%h exp=0002", v); end
    checks++;
    pulse_ack();
    if (valid !== 1'b0) begin failures++; $display("FAIL ack_clear got=%b exp=0", valid); end
    checks++;
    hw(2'd1, 16'h0007, 0);
    hw(2'd1, 16'h0003, 1);
    hr(2'd3, 0, 16'h0, v, e, k);
    if (v !== 16'h0002 || rdata !== 16'h0003) begin failures++; $display("FAIL ack_commit got=%h/%h exp=0002/0003", v, rdata); end
    checks++;
    pulse_ack();
  endtask
  task automatic test_back_to_back();
    logic [15:0] v, e;
    bit k;
    hw(2'd2, 16'h0200, 0);
    hw(2'd0, 16'h1111, 0);
    hw(2'd0, 16'h2222, 0);
    hw(2'd2, 16'h0200, 0);
    for (int i = 0; i < 2; i++) begin
      hr(2'd0, 0, 16'h0, v, e, k);
      if (v !== e) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, v, e); end
      checks++;
    end
    hw(2'd2, 16'h0300, 0);
    hr(2'd2, 0, 16'h0, v, e, k);
    if (v !== 16'h0300) begin failures++; $display("FAIL b2b_addr got=%h exp=0300", v); end
    checks++;
  endtask
  task automatic test_conflict();
    logic [15:0] v, e;
    bit k;
    hw(2'd2, 16'h0100, 0);
    a = 2'd2; cs_n = 0; rd_n = 0; wr_n = 0;
    repeat (4) @(negedge clk);
    v = bus;
    if (v !== 16'h0100) begin failures++; $display("FAIL conflict_read got=%h exp=0100", v); end
    checks++;
    rd_n = 1;
    repeat (3) @(negedge clk);
    wr_n = 1; cs_n = 1;
    repeat (3) @(negedge clk);
    hr(2'd2, 0, 16'h0, v, e, k);
    if (v !== 16'h0100) begin failures++; $display("FAIL conflict_nowrite got=%h exp=0100", v); end
    checks++;
  endtask
  task automatic test_reset_mid();
    logic [15:0] v, e;
    bit k;
    hw(2'd2, 16'h0040, 0);
    hw(2'd0, 16'h7777, 0);
    hw(2'd1, 16'h4444, 0);
    post(16'h5555);
    a = 2'd2; tb_d = 16'h0123; tb_oe = 1; cs_n = 0; wr_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    wr_n = 1; cs_n = 1; tb_oe = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    m_reset();
    if ({irq, valid, busy} !== 3'b000 || rdata !== 16'h0) begin failures++; $display("FAIL softrst_mbx got=%b/%h exp=000/0000", {irq, valid, busy}, rdata); end
    checks++;
    hr(2'd2, 0, 16'h0, v, e, k);
    if (v !== 16'h0000) begin failures++; $display("FAIL softrst_addr got=%h exp=0000", v); end
    checks++;
    hw(2'd2, 16'h0040, 0);
    hr(2'd0, 0, 16'h0, v, e, k);
    if (v !== 16'h7777) begin failures++; $display("FAIL mem_retained got=%h exp=7777", v); end
    checks++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      int op = int'($urandom_range(0, 5));
      logic [1:0] r = 2'($urandom_range(0, 3));
      logic [15:0] d = 16'($urandom);
      logic [15:0] v, e;
      bit k;
      if (r == 2'd2) d = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 31) * 2 + $urandom_range(0, 3) * 16'h0800);
      case (op)
        0, 1: hw(r, d, 1'($urandom_range(0, 1)));
        2, 3: begin
          hr(r, 1'($urandom_range(0, 1)), 16'($urandom), v, e, k);
          if (k) begin
            if (v !== e) begin failures++; $display("FAIL rand_read[%0d] reg=%0d got=%h exp=%h", i, r, v, e); end
            checks++;
          end
        end
        4: post(d);
        default: pulse_ack();
      endcase
      @(negedge clk);
      if ({irq, busy, valid} !== {m_busy, m_busy, m_hval}) begin failures++; $display("FAIL rand_flags[%0d] got=%b exp=%b", i, {irq, busy, valid}, {m_busy, m_busy, m_hval}); end
      checks++;
      if (rdata !== m_hdat) begin failures++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, rdata, m_hdat); end
      checks++;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; cs_n = 1; rd_n = 1; wr_n = 1; rst_n = 1; ack = 0; dwr = 0; tb_oe = 0;
    a = 0; tb_d = 0; dwd = 0;
    @(negedge clk);
    test_reset();
    test_autoinc();
    test_wrap();
    test_dev_mbx();
    test_host_mbx();
    test_back_to_back();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hpi_target.md
# hpi_target

Synthesizable responder for the CY7C67200 Host Port Interface: the chip-side end of the 4-register HPI bus that `hpi_io_intf` drives. It decodes host strobes on the OTG_* pins and serves DATA/MAILBOX/ADDRESS/STATUS accesses against an internal word memory. It also exposes mailbox handshakes to a local device agent. It is used as a bench and loopback stand-in for the EZ-OTG chip, so NIOS HPI drivers can run without silicon.

## Interface
- `MEM_WORDS`, default 1024 — internal memory depth in 16-bit words, power of 2.
- `MIN_RD_CYC`, default 3 — documented minimum host RD_N low time in Clk cycles. Not enforced.
- `Clk` in 1 — single clock. All OTG_* inputs are synchronous to it.
- `Reset` in 1 — synchronous, active-high.
- `OTG_DATA` inout 16 — HPI data bus. Driven only during a read.
- `OTG_ADDR` in 2 — register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- `OTG_CS_N`, `OTG_RD_N`, `OTG_WR_N` in 1 each — active-low strobes.
- `OTG_RST_N` in 1 — active-low soft reset.
- `OTG_INT` out 1 — high while the device mailbox is full.
- `dev_mbx_rdata` out 16 — last host-written mailbox word.
- `dev_mbx_valid` out 1 — host mailbox full.
- `dev_mbx_ack` in 1 — pulse; clears `dev_mbx_valid`.
- `dev_mbx_wdata` in 16, `dev_mbx_wr` in 1 — device posts a word to the host.
- `dev_mbx_busy` out 1 — device mailbox full. A `dev_mbx_wr` while busy is dropped.

## Operation
- **Input registering:** CS_N, RD_N, WR_N, ADDR and DATA are registered once (stage s1). A second stage s2 holds the previous value of the strobes for edge detection.
- **FSM states:**
  - IDLE → RD_LATCH when s1 CS_N=0, RD_N=0 and s2 RD_N=1.
  - IDLE → WR_HOLD when s1 CS_N=0 and WR_N=0.
  - RD_LATCH: capture `rd_q` ← selected register. For DATA, `rd_q` ← mem[addr[AW:1]]. Next state RD_DRIVE.
  - RD_DRIVE: stay while s1 RD_N=0. On RD_N rising edge, do the post-access increment, then go to IDLE.
  - WR_HOLD: load `wr_q` ← s1 DATA every cycle while WR_N=0. On WR_N rising edge, go to COMMIT.
  - COMMIT: perform the write using the latched ADDR, then go to IDLE.
- **Bus drive:** OTG_DATA = `rd_q` when FSM is in RD_DRIVE and raw CS_N=0 and RD_N=0. Otherwise 'z.
- **Registers:**
  - ADDRESS: 16-bit byte address. R/W.
  - DATA: memory word at ADDRESS, with post-increment (see Configuration).
  - MAILBOX write: `dev_mbx_rdata` ← data, `dev_mbx_valid` ← 1. If it was already 1, set the `ovr` sticky bit.
  - MAILBOX read: returns the device mailbox word and clears `dev_mbx_busy`/`OTG_INT`.
  - STATUS: read-only, {13'b0, ovr, dev_mbx_valid, dev_mbx_busy}. A STATUS write clears `ovr`. All other STATUS write bits are ignored.
- **Wrap-around:** word index = addr[AW:1] mod MEM_WORDS. Address increment wraps 0xFFFE → 0x0000.
- **Simultaneous events:**
  - Host MAILBOX read clear and `dev_mbx_wr` in the same cycle: the write wins, and busy stays 1 with the new data.
  - `dev_mbx_ack` and host MAILBOX commit in the same cycle: the commit wins, valid stays 1, `ovr` is not set.
- **Conflicting strobes:** RD_N and WR_N both low in IDLE → read takes priority, and the write is ignored until both strobes return high.
- **Reset** (Reset=1, or s1 OTG_RST_N=0):
  - FSM → IDLE; ADDRESS, `rd_q`, `wr_q`, `ovr` = 0.
  - Both mailboxes empty: `OTG_INT`, `dev_mbx_valid`, `dev_mbx_busy` = 0; `dev_mbx_rdata` = 0.
  - OTG_DATA released.
  - Memory contents are retained.
  - A reset mid-access aborts the access with no commit and no increment.

## Timing
- Pin change → s1: 1 cycle.
- **Read:** RD_N falling at pin edge k → `rd_q` valid at k+2 → OTG_DATA driven from k+2. The host must hold RD_N low ≥ MIN_RD_CYC cycles.
- **Write:** the commit occurs 2 cycles after the WR_N rising pin edge. DATA is sampled from the last cycle WR_N was low.
- **Back-to-back:** a new access is accepted the cycle after COMMIT, or the cycle after the RD_DRIVE exit.
- **Device mailbox:** `dev_mbx_wr` at edge k → `dev_mbx_busy` and `OTG_INT` are 1 after k.
- **Host mailbox:** `dev_mbx_ack` at edge k → `dev_mbx_valid` is 0 after k.

## Configuration
- `HPI_TARGET_AUTOINC_EN` defined: every DATA read or write post-increments ADDRESS by 2, matching chip behaviour.
- Undefined: ADDRESS changes only on writes to the ADDRESS register, and DATA accesses repeat the same word.

## Test plan
- Reset, then read STATUS → 0x0000. OTG_DATA is 'z outside read windows.
- Write ADDRESS=0x1000, then DATA ×3 with 0xA1, 0xB2, 0xC3. Write ADDRESS=0x1000, read DATA ×3 → 0xA1, 0xB2, 0xC3. With AUTOINC undefined, the three reads return 0xC3 each.
- Write ADDRESS=0xFFFE, write DATA 0x5555, then read ADDRESS → 0x0000 (AUTOINC defined).
- Device pulses `dev_mbx_wr` with 0x1234 → OTG_INT=1, STATUS=0x0001. Host reads MAILBOX → 0x1234, and OTG_INT=0 two cycles after RD_N rises.
- Host writes MAILBOX 0x0001 then 0x0002 with no ack → `dev_mbx_rdata`=0x0002, STATUS=0x0006. Writing STATUS then gives 0x0002.
- Assert OTG_RST_N low mid-write (WR_N still low) → no commit, ADDRESS=0. Memory word written earlier is still readable.
